// File: rtl/user_dma_wr_buffer_pkg.sv
// Shared definitions for the user DMA write-side buffer.
// Holds the default bus widths, which are common with the request arbitrator,
// and the burst FSM state encoding.
package user_dma_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_DMA_LEN    = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        AVAIL = 1'b1
    } wr_state_t;

endpackage

// File: rtl/user_dma_wr_buffer_if.sv
// Slave-port bundle between a write-side DMA source and the request arbitrator.
//   data_avail : burst ready (source -> arbitrator)
//   wr_addr    : host byte address of the burst (source -> arbitrator)
//   len        : burst length in data words (source -> arbitrator)
//   data       : FWFT head word (source -> arbitrator)
//   data_rd    : pop one word per asserted cycle (arbitrator -> source)
//   done       : single-cycle burst-finished pulse (arbitrator -> source)
interface user_dma_wr_buffer_if
    import user_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DMA_LEN    = DEF_DMA_LEN
) ();

    logic                  data_avail;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DMA_LEN-1:0]    len;
    logic [DATA_WIDTH-1:0] data;
    logic                  data_rd;
    logic                  done;

    modport master (
        output data_avail, wr_addr, len, data,
        input  data_rd, done
    );

    modport slave (
        input  data_avail, wr_addr, len, data,
        output data_rd, done
    );

endinterface

// File: rtl/user_dma_fwft_fifo.sv
// First-word-fall-through FIFO used as the local write buffer.
//   clk, rst   : clock and asynchronous active-high reset
//   push       : write push_data (caller guarantees !full)
//   pop        : drop the head word (caller guarantees !empty)
//   head       : current head word, zero read latency
//   count      : number of stored words
//   full       : registered from the next-state count, so it never depends
//                combinationally on this cycle's pop
//   empty      : count == 0
module user_dma_fwft_fifo #(
    parameter  int DATA_WIDTH = 64,
    parameter  int FIFO_DEPTH = 32,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_idx;
    logic [AW-1:0]         rd_idx;
    logic [CW-1:0]         count_nxt;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) wr_idx <= wr_idx + 1'b1;
            if (pop)  rd_idx <= rd_idx + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == CW'(FIFO_DEPTH));
        end
    end

    // Storage carries no reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) mem[wr_idx] <= push_data;
    end

    assign head  = mem[rd_idx];
    assign empty = (count == '0);

endmodule

// File: rtl/user_dma_wr_buffer.sv
// Write-side DMA source for one slave port of the user DMA request arbitrator.
// Buffers a valid/ready user stream, cuts it into bursts and walks a circular
// host buffer as each burst completes.
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_base_addr         : host buffer base (word aligned)
//   i_buf_size          : host buffer size in bytes (multiple of a full burst)
//   i_enable            : rising edge reloads the write pointer; low blocks new bursts
//   i_data_valid/i_data : user stream in; o_data_ready while the buffer has room
//   i_flush             : request to drain a partial burst; o_flush_done when drained
//   dma                 : arbitrator slave port (master side of the bundle)
//   o_burst_cnt         : completed bursts, wrapping
//   o_err               : sticky protocol error (over-read or short burst)
module user_dma_wr_buffer
    import user_dma_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DMA_LEN     = DEF_DMA_LEN,
    parameter int FIFO_DEPTH  = 32,
    parameter int BURST_WORDS = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH-1:0] i_buf_size,
    input  logic                  i_enable,
    input  logic                  i_data_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_data_ready,
    input  logic                  i_flush,
    output logic                  o_flush_done,
    user_dma_wr_buffer_if.master  dma,
    output logic [31:0]           o_burst_cnt,
    output logic                  o_err
);

    localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
    localparam int              BYTES     = DATA_WIDTH / 8;
    localparam logic [CW-1:0]   BURST_CNT = CW'(BURST_WORDS);

    wr_state_t             state;
    wr_state_t             state_nxt;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [DMA_LEN-1:0]    len;
    logic [DMA_LEN-1:0]    rd_cnt;
    logic [DMA_LEN-1:0]    rd_final;
    logic [DMA_LEN-1:0]    burst_len;
    logic                  flush_pending;
    logic                  enable_d;
    logic                  start_burst;
    logic                  flush_clr;

    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;

    // Next burst address; the sum wraps modulo 2^ADDR_WIDTH before the compare.
    function automatic logic [ADDR_WIDTH-1:0] advance_ptr(
        input logic [ADDR_WIDTH-1:0] ptr,
        input logic [ADDR_WIDTH-1:0] base,
        input logic [ADDR_WIDTH-1:0] size,
        input logic [DMA_LEN-1:0]    blen
    );
        logic [ADDR_WIDTH-1:0] sum;
        logic [ADDR_WIDTH-1:0] limit;
        sum   = ptr + ADDR_WIDTH'(blen) * ADDR_WIDTH'(BYTES);
        limit = base + size;
        return (sum >= limit) ? base : sum;
    endfunction

    user_dma_fwft_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (push),
        .push_data (i_data),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign o_data_ready = !full;
    assign push         = i_data_valid && !full;
    assign pop          = (state == AVAIL) && dma.data_rd && (rd_cnt < len);
    assign rd_final     = rd_cnt + {{(DMA_LEN-1){1'b0}}, pop};
    assign burst_len    = (count >= BURST_CNT) ? DMA_LEN'(BURST_WORDS) : DMA_LEN'(count);

    assign dma.data_avail = (state == AVAIL);
    assign dma.wr_addr    = wr_ptr;
    assign dma.len        = len;
    // Head is masked outside a burst so the port reads zero rather than stale storage.
    assign dma.data       = (state == AVAIL) ? head : '0;

    always_comb begin
        state_nxt   = state;
        start_burst = 1'b0;
        flush_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (i_enable && (count >= BURST_CNT)) begin
                    start_burst = 1'b1;
                    state_nxt   = AVAIL;
                end else if (i_enable && flush_pending && !empty) begin
                    start_burst = 1'b1;
                    state_nxt   = AVAIL;
                end else if (flush_pending && empty) begin
                    flush_clr = 1'b1;
                end
            end
            AVAIL: begin
                // Always returning through IDLE guarantees data_avail drops for a
                // cycle after done, so the arbitrator never sees a stale request.
                if (dma.done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr        <= '0;
            len           <= '0;
            rd_cnt        <= '0;
            flush_pending <= 1'b0;
            enable_d      <= 1'b0;
            o_flush_done  <= 1'b0;
            o_burst_cnt   <= '0;
            o_err         <= 1'b0;
        end else begin
            enable_d     <= i_enable;
            o_flush_done <= flush_clr;

            if (flush_clr)    flush_pending <= 1'b0;
            else if (i_flush) flush_pending <= 1'b1;

            if ((state == IDLE) && i_enable && !enable_d) wr_ptr <= i_base_addr;

            if (start_burst) begin
                len    <= burst_len;
                rd_cnt <= '0;
            end

            if (state == AVAIL) begin
                if (pop) rd_cnt <= rd_cnt + 1'b1;
                if (dma.data_rd && (rd_cnt == len)) o_err <= 1'b1;
                if (dma.done) begin
                    if (rd_final != len) o_err <= 1'b1;
                    wr_ptr      <= advance_ptr(wr_ptr, i_base_addr, i_buf_size, len);
                    o_burst_cnt <= o_burst_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_user_dma_wr_buffer.sv
// Bench for user_dma_wr_buffer: drives the user stream and emulates the
// arbitrator; a negedge monitor scores head words against a queue of accepted
// stream words and tracks FIFO occupancy to predict o_data_ready.
module tb_user_dma_wr_buffer;

    localparam int AW    = 32;
    localparam int DW    = 64;
    localparam int LW    = 5;
    localparam int DEPTH = 32;
    localparam int BW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] buf_size;
    logic          enable;
    logic          data_valid;
    logic [DW-1:0] data;
    logic          data_ready;
    logic          flush;
    logic          flush_done;
    logic [31:0]   burst_cnt;
    logic          err;

    user_dma_wr_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DMA_LEN(LW)) dma ();

    user_dma_wr_buffer #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .DMA_LEN     (LW),
        .FIFO_DEPTH  (DEPTH),
        .BURST_WORDS (BW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_base_addr  (base_addr),
        .i_buf_size   (buf_size),
        .i_enable     (enable),
        .i_data_valid (data_valid),
        .i_data       (data),
        .o_data_ready (data_ready),
        .i_flush      (flush),
        .o_flush_done (flush_done),
        .dma          (dma),
        .o_burst_cnt  (burst_cnt),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] exp_q[$];
    int            mcount     = 0;
    int            mrd        = 0;
    int            mlen       = 0;
    logic          prev_avail = 1'b0;
    logic [AW-1:0] exp_addr   = '0;
    logic [AW-1:0] model_ptr  = '0;
    int            exp_len    = 0;
    int            m_bursts   = 0;
    int            acc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: header, data and ready scoring, decoupled from stimulus.
    always @(negedge clk) begin
        if (rst) begin
            mcount     = 0;
            mrd        = 0;
            prev_avail = 1'b0;
        end else begin
            chk("data_ready", data_ready, mcount < DEPTH);
            if (dma.data_avail && !prev_avail) begin
                chk("burst_addr", dma.wr_addr, exp_addr);
                chk("burst_len", dma.len, exp_len);
                mlen = exp_len;
                mrd  = 0;
            end
            if (dma.data_avail && dma.data_rd && mrd < mlen) begin
                if (exp_q.size() == 0) chk("data_underflow", 1, 0);
                else                   chk("burst_data", dma.data, exp_q.pop_front());
                mrd++;
                mcount--;
            end
            if (data_valid && data_ready) mcount++;
            prev_avail = dma.data_avail;
        end
    end

    task automatic check_reset_vals();
        chk("rst_avail", dma.data_avail, 0);
        chk("rst_addr", dma.wr_addr, 0);
        chk("rst_len", dma.len, 0);
        chk("rst_data", dma.data, 0);
        chk("rst_ready", data_ready, 1);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_burst_cnt", burst_cnt, 0);
        chk("rst_err", err, 0);
    endtask

    // Called at posedge+1; leaves the model in its post-reset state.
    task automatic do_reset();
        rst         = 1'b1;
        data_valid  = 1'b0;
        flush       = 1'b0;
        dma.data_rd = 1'b0;
        dma.done    = 1'b0;
        #1;
        check_reset_vals();
        @(posedge clk); #1;
        exp_q.delete();
        m_bursts  = 0;
        model_ptr = base_addr;
        exp_addr  = base_addr;
        rst       = 1'b0;
    endtask

    // Offers n words (sequential from start, or random) with random idle gaps.
    task automatic push_words(input int n, input bit rnd, input logic [DW-1:0] start,
                              output int accepted);
        int            waited;
        logic [DW-1:0] v;
        waited   = 0;
        accepted = 0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                data_valid = 1'b0;
                @(posedge clk); #1;
            end
            v          = rnd ? {$urandom, $urandom} : start + DW'(i);
            data_valid = 1'b1;
            data       = v;
            while (!data_ready && waited < 8) begin
                @(posedge clk); #1;
                waited++;
            end
            if (!data_ready) break;
            exp_q.push_back(v);
            accepted++;
            @(posedge clk); #1;
        end
        data_valid = 1'b0;
    endtask

    // Arbitrator side: waits for data_avail, reads n_rd cycles, pulses done.
    task automatic run_burst(input int n_rd);
        int t;
        t = 0;
        while (!dma.data_avail && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        if (!dma.data_avail) begin
            chk("avail_timeout", 0, 1);
            return;
        end
        for (int i = 0; i < n_rd; i++) begin
            dma.data_rd = 1'b1;
            @(posedge clk); #1;
        end
        dma.data_rd = 1'b0;
        dma.done    = 1'b1;
        @(posedge clk); #1;
        dma.done = 1'b0;
        chk("avail_gap", dma.data_avail, 0);
        m_bursts++;
        model_ptr = model_ptr + AW'(exp_len * (DW / 8));
        if (model_ptr >= base_addr + buf_size) model_ptr = base_addr;
        exp_addr = model_ptr;
        chk("burst_cnt", burst_cnt, m_bursts);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int pulses;
        int t;
        base_addr = 32'h1000;
        buf_size  = 32'h400;
        enable    = 1'b0;
        data      = '0;
        do_reset();

        // Single burst of a known ramp.
        enable  = 1'b1;
        exp_len = BW;
        push_words(16, 1'b0, 64'h1, acc);
        run_burst(16);
        chk("err_clean", err, 0);

        // Eight more bursts; the last wraps back to the base.
        for (int b = 0; b < 8; b++) begin
            push_words(16, 1'b1, '0, acc);
            run_burst(16);
        end
        chk("wrap_ptr_model", model_ptr, 32'h1080);

        // Partial burst through flush.
        exp_len = 5;
        push_words(5, 1'b1, '0, acc);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        run_burst(5);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (flush_done) pulses++;
            @(posedge clk); #1;
        end
        chk("flush_done_pulses", pulses, 1);
        chk("flush_empty", exp_q.size(), 0);

        // Fill with bursts disabled, then enable to drain from a reloaded base.
        enable = 1'b0;
        @(posedge clk); #1;
        push_words(33, 1'b1, '0, acc);
        chk("full_accept", acc, 32);
        chk("ready_full", data_ready, 0);
        chk("no_burst_disabled", dma.data_avail, 0);
        exp_len   = BW;
        model_ptr = base_addr;
        exp_addr  = base_addr;
        enable    = 1'b1;
        run_burst(16);
        run_burst(16);

        // Over-read: 17 read cycles on a 16-word burst.
        push_words(16, 1'b1, '0, acc);
        run_burst(17);
        chk("err_overread", err, 1);
        do_reset();

        // Done arrives before the burst has been fully read.
        push_words(16, 1'b1, '0, acc);
        run_burst(10);
        chk("err_short", err, 1);
        do_reset();

        // Asynchronous reset mid-burst, then a fresh burst from the base.
        push_words(16, 1'b1, '0, acc);
        t = 0;
        while (!dma.data_avail && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        chk("pre_reset_avail", dma.data_avail, 1);
        for (int i = 0; i < 4; i++) begin
            dma.data_rd = 1'b1;
            @(posedge clk); #1;
        end
        dma.data_rd = 1'b0;
        #2;
        do_reset();
        push_words(16, 1'b1, '0, acc);
        run_burst(16);
        chk("err_after_reset", err, 0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
